// File: rtl/krnl_partialknn_sp_pkg.sv
// Shared defaults, FSM state encoding and sizing helper for the scratchpad stream reader.
package krnl_partialknn_sp_pkg;

    localparam int DATA_WIDTH_DEF    = 256;
    localparam int ADDRESS_RANGE_DEF = 2048;
    localparam int ADDRESS_WIDTH_DEF = 11;
    localparam int READ_LATENCY_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sr_state_e;

    // Two extra slots beyond the read pipeline let the stream sustain one beat per
    // cycle while still guaranteeing room for every outstanding read.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/krnl_partialknn_sp_skid_fifo.sv
// Small register-based FIFO that absorbs returning scratchpad words while the
// output stream is stalled. The head entry is presented directly from storage.
module krnl_partialknn_sp_skid_fifo #(
    parameter int Width = 256,
    parameter int Depth = 4,
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [Width-1:0] out_data,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_reg [Depth];
    logic [PtrW-1:0]  rd_ptr_reg;
    logic [PtrW-1:0]  wr_ptr_reg;
    logic [CntW-1:0]  count_reg;
    logic             push_en;
    logic             pop_en;
    logic [Depth-1:0] wr_sel;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign pop_en  = pop && (count_reg != '0);
    assign push_en = push && ((count_reg != CntW'(Depth)) || pop_en);

    // One write-select line per storage entry.
    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_en && (wr_ptr_reg == PtrW'(gi));
        end
    endgenerate

    // Storage entries; cleared on reset so the presented head starts at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < Depth; k++) begin
                mem_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < Depth; k++) begin
                if (wr_sel[k]) begin
                    mem_reg[k] <= push_data;
                end
            end
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_en) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + CntW'(1);
                2'b01:   count_reg <= count_reg - CntW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_valid = (count_reg != '0);
    assign out_data  = out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: rtl/krnl_partialknn_sp_stream_reader.sv
// Reads a contiguous (wrapping) run of scratchpad words and streams them out with
// valid/ready flow control. Reads are only issued when the skid FIFO is certain to
// have room for the returning word, so nothing is lost under back-pressure.
module krnl_partialknn_sp_stream_reader
    import krnl_partialknn_sp_pkg::*;
#(
    parameter int DataWidth    = DATA_WIDTH_DEF,
    parameter int AddressRange = ADDRESS_RANGE_DEF,
    parameter int AddressWidth = ADDRESS_WIDTH_DEF,
    parameter int ReadLatency  = READ_LATENCY_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AddressWidth-1:0] cmd_base,
    input  logic [AddressWidth:0]   cmd_len,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    output logic                    we0,
    output logic [DataWidth-1:0]    d0,
    input  logic [DataWidth-1:0]    q0,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DataWidth-1:0]    out_data,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);

    localparam int FifoDepth = fifo_depth(ReadLatency);
    localparam int CntW      = $clog2(FifoDepth + 1);
    localparam int LenW      = AddressWidth + 1;
    localparam logic [LenW-1:0]         LenMax   = LenW'(AddressRange);
    localparam logic [AddressWidth-1:0] AddrLast = AddressWidth'(AddressRange - 1);

    sr_state_e               state_reg;
    sr_state_e               state_next;
    logic [AddressWidth-1:0] addr_reg;
    logic [LenW-1:0]         len_reg;
    logic [LenW-1:0]         issue_cnt_reg;
    logic [LenW-1:0]         beat_cnt_reg;
    logic [ReadLatency-1:0]  vld_sr_reg;
    logic [ReadLatency-1:0]  vld_sr_next;

    logic [LenW-1:0] len_clamped;
    logic [CntW-1:0] in_flight;
    logic [CntW-1:0] fifo_count;
    logic [CntW:0]   occupancy;
    logic            room;
    logic            accept;
    logic            issue;
    logic            drained;
    logic            beat;
    logic            fifo_valid;

    assign len_clamped = (cmd_len > LenMax) ? LenMax : cmd_len;
    assign accept      = (state_reg == ST_IDLE) && cmd_valid;
    assign occupancy   = {1'b0, in_flight} + {1'b0, fifo_count};
    assign room        = (occupancy < (CntW + 1)'(FifoDepth));
    assign issue       = (state_reg == ST_ISSUE) && room;
    assign drained     = (in_flight == '0) && (fifo_count == '0);
    assign beat        = fifo_valid && out_ready;

    // Read-valid pipeline: bit gi marks a read issued gi+1 cycles ago.
    generate
        for (genvar gi = 0; gi < ReadLatency; gi++) begin : g_vld_sr
            if (gi == 0) begin : g_head
                assign vld_sr_next[gi] = issue;
            end else begin : g_tail
                assign vld_sr_next[gi] = vld_sr_reg[gi-1];
            end
        end
    endgenerate

    // Count of reads whose data has not yet landed in the FIFO.
    always_comb begin
        in_flight = '0;
        for (int k = 0; k < ReadLatency; k++) begin
            in_flight = in_flight + CntW'(vld_sr_reg[k]);
        end
    end

    // State register and read-valid pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            vld_sr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            vld_sr_reg <= vld_sr_next;
        end
    end

    // Next-state logic and control outputs.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_next = (len_clamped == '0) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && (issue_cnt_reg == len_reg - LenW'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command registers, wrapping read address and issue/beat counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg      <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            beat_cnt_reg  <= '0;
        end else if (accept) begin
            addr_reg      <= cmd_base;
            len_reg       <= len_clamped;
            issue_cnt_reg <= '0;
            beat_cnt_reg  <= '0;
        end else begin
            if (issue) begin
                addr_reg      <= (addr_reg >= AddrLast) ? '0 : addr_reg + AddressWidth'(1);
                issue_cnt_reg <= issue_cnt_reg + LenW'(1);
            end
            if (beat) begin
                beat_cnt_reg <= beat_cnt_reg + LenW'(1);
            end
        end
    end

    krnl_partialknn_sp_skid_fifo #(
        .Width (DataWidth),
        .Depth (FifoDepth)
    ) u_skid_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_sr_reg[ReadLatency-1]),
        .push_data (q0),
        .pop       (beat),
        .out_valid (fifo_valid),
        .out_data  (out_data),
        .count     (fifo_count)
    );

    assign ce0       = issue;
    assign address0  = addr_reg;
    assign we0       = 1'b0;
    assign d0        = '0;
    assign out_valid = fifo_valid;
    assign out_last  = fifo_valid && (beat_cnt_reg == len_reg - LenW'(1));

endmodule

// File: tb/tb_krnl_partialknn_sp_stream_reader.sv
// Directed bench for the scratchpad stream reader: a 2-cycle scratchpad model,
// a negedge monitor logging reads/beats/done, and hand-derived expectations.
module tb_krnl_partialknn_sp_stream_reader;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [10:0]  cmd_base;
    logic [11:0]  cmd_len;
    logic [10:0]  address0;
    logic         ce0;
    logic         we0;
    logic [255:0] d0;
    logic [255:0] q0;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    krnl_partialknn_sp_stream_reader dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .address0  (address0),
        .ce0       (ce0),
        .we0       (we0),
        .d0        (d0),
        .q0        (q0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int           ce_cyc[$];
    logic [10:0]  ce_addr[$];
    int           beat_cyc[$];
    logic [255:0] beat_data[$];
    logic         beat_last[$];
    int           done_cyc[$];
    int           outstanding = 0;
    int           max_out = 0;
    int           stall_viol = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_data = '0;
    logic [255:0] spad_s1 = '0;

    function automatic logic [255:0] word_of(input logic [10:0] a);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*32 +: 32] = {5'(j), 16'hC3A5, a};
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scratchpad model: data for the address presented with ce0 appears on q0 two
    // cycles later; otherwise q0 carries a filler pattern.
    initial begin
        q0 = '0;
        forever begin
            @(posedge clk);
            q0      <= spad_s1;
            spad_s1 <= ce0 ? word_of(address0) : {8{32'hDEADBEEF}};
        end
    end

    // Monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            if (ce0) begin
                ce_cyc.push_back(cyc);
                ce_addr.push_back(address0);
            end
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
            end
            if (done) done_cyc.push_back(cyc);
            if (prev_stall && (!out_valid || out_data !== prev_data)) stall_viol++;
            outstanding = outstanding + (ce0 ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
            if (outstanding > max_out) max_out = outstanding;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end else begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end
    end

    task automatic clear_logs();
        ce_cyc.delete();
        ce_addr.delete();
        beat_cyc.delete();
        beat_data.delete();
        beat_last.delete();
        done_cyc.delete();
        max_out    = 0;
        stall_viol = 0;
    endtask

    // Offers a command and returns the cycle in which it was accepted.
    task automatic send_cmd(input logic [10:0] b, input logic [11:0] l, output int t);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_base  = b;
        cmd_len   = l;
        t = -1;
        for (int k = 0; k < 64 && t < 0; k++) begin
            @(negedge clk);
            if (cmd_ready) t = cyc;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", t >= 0, 1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done_cyc.size() == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_done_seen"}, done_cyc.size() != 0, 1);
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    // Checks the logged read addresses, beat data, last flags and done count.
    task automatic check_stream(input string tag, input int base, input int len);
        int bad_addr = 0;
        int bad_data = 0;
        int bad_last = 0;
        chk({tag, "_ce_count"}, ce_addr.size(), len);
        for (int i = 0; i < ce_addr.size() && i < len; i++) begin
            if (ce_addr[i] !== 11'((base + i) % 2048)) bad_addr++;
        end
        chk({tag, "_addr_errs"}, bad_addr, 0);
        chk({tag, "_beat_count"}, beat_data.size(), len);
        for (int i = 0; i < beat_data.size() && i < len; i++) begin
            if (beat_data[i] !== word_of(11'((base + i) % 2048))) bad_data++;
            if (beat_last[i] !== (i == len - 1)) bad_last++;
        end
        chk({tag, "_data_errs"}, bad_data, 0);
        chk({tag, "_last_errs"}, bad_last, 0);
        chk({tag, "_done_count"}, done_cyc.size(), 1);
    endtask

    initial begin
        int t;
        logic [63:0] pat;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ce0", ce0, 0);
        chk("rst_address0", address0, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we0", we0, 0);
        chk("rst_d0", d0, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        clear_logs();

        // base=5, len=4, out_ready=1: exact cycle timing
        send_cmd(11'd5, 12'd4, t);
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_cmd_ready_busy", cmd_ready, 0);
        wait_done(40, "t1");
        check_stream("t1", 5, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ce_cyc.size()) chk($sformatf("t1_ce_cyc%0d", i), ce_cyc[i] - t, 1 + i);
            if (i < beat_cyc.size()) chk($sformatf("t1_beat_cyc%0d", i), beat_cyc[i] - t, 4 + i);
        end
        if (done_cyc.size() > 0) chk("t1_done_cyc", done_cyc[0] - t, 8);
        chk("t1_idle_busy", busy, 0);
        clear_logs();

        // base=2046, len=4: address wrap, data order preserved
        send_cmd(11'd2046, 12'd4, t);
        wait_done(40, "t2");
        check_stream("t2", 2046, 4);
        clear_logs();

        // len=16 with back-pressure, including a 3-cycle stall at T+4..T+6
        pat = '1;
        pat[4]  = 1'b0;
        pat[5]  = 1'b0;
        pat[6]  = 1'b0;
        pat[11] = 1'b0;
        pat[15] = 1'b0;
        pat[16] = 1'b0;
        pat[22] = 1'b0;
        send_cmd(11'd100, 12'd16, t);
        for (int k = 1; k <= 40; k++) begin
            out_ready = pat[k];
            @(negedge clk);
            if (k == 4) chk("t3_ce0_stall_start", ce0, 1);
            if (k == 5) chk("t3_ce0_stall_mid", ce0, 0);
            if (k == 6) chk("t3_ce0_stall_end", ce0, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(100, "t3");
        check_stream("t3", 100, 16);
        chk("t3_max_outstanding", max_out, 4);
        chk("t3_stall_hold_errs", stall_viol, 0);
        clear_logs();

        // len=0: no reads, no beats, done at T+1, ready again at T+2
        send_cmd(11'd33, 12'd0, t);
        @(negedge clk);
        chk("t4_cmd_ready_t1", cmd_ready, 0);
        chk("t4_done_t1", done, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_cmd_ready_t2", cmd_ready, 1);
        wait_done(20, "t4");
        check_stream("t4", 33, 0);
        if (done_cyc.size() > 0) chk("t4_done_cyc", done_cyc[0] - t, 1);
        clear_logs();

        // Oversized length is clamped to the scratchpad depth
        send_cmd(11'd7, 12'd2049, t);
        wait_done(2300, "t5");
        check_stream("t5", 7, 2048);
        clear_logs();

        // Reset mid-DRAIN with two words buffered, then a clean len=1 command
        out_ready = 1'b0;
        send_cmd(11'd10, 12'd4, t);
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t6_busy_pre", busy, 1);
        chk("t6_out_valid_pre", out_valid, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_cmd_ready", cmd_ready, 1);
        chk("t6_rst_ce0", ce0, 0);
        chk("t6_rst_address0", address0, 0);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_last", out_last, 0);
        chk("t6_rst_out_data", out_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("t6_no_done_aborted", done_cyc.size(), 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        send_cmd(11'd20, 12'd1, t);
        wait_done(40, "t6");
        check_stream("t6", 20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
